// File: rtl/rat_io_pkg.sv
// Shared RAT port-bus definitions: port IDs, status/control bit positions,
// and the UART transmitter state type.
package rat_io_pkg;

  localparam logic [7:0] SWITCHES_PORT_ID = 8'h20;
  localparam logic [7:0] LEDS_PORT_ID     = 8'h40;
  localparam logic [7:0] DATA_PORT_ID     = 8'h44;
  localparam logic [7:0] CTRL_PORT_ID     = 8'h45;
  localparam logic [7:0] STATUS_PORT_ID   = 8'h25;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_HOLD_FULL = 1;
  localparam int STAT_PEND      = 2;
  localparam int STAT_OVF       = 3;

  localparam int CTRL_INTR_EN  = 0;
  localparam int CTRL_CLR_PEND = 1;
  localparam int CTRL_CLR_OVF  = 2;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

  // Clocks per serial bit, never below 2 so the baud counter has a real wrap.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    int c;
    c = clk_freq / baud;
    return (c < 2) ? 2 : c;
  endfunction

endpackage

// File: rtl/rat_uart_tx_port_if.sv
// RAT MCU port bus as seen by one peripheral: write address/data/strobe
// from the MCU and the read-side contribution back to the wrapper mux.
interface rat_uart_tx_port_if;

  logic [7:0] PORT_ID;
  logic [7:0] OUT_PORT;
  logic       IO_STRB;
  logic [7:0] IN_DATA;
  logic       IN_SEL;

  modport master (
    output PORT_ID,
    output OUT_PORT,
    output IO_STRB,
    input  IN_DATA,
    input  IN_SEL
  );

  modport slave (
    input  PORT_ID,
    input  OUT_PORT,
    input  IO_STRB,
    output IN_DATA,
    output IN_SEL
  );

endinterface

// File: rtl/rat_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and pulses tick on the last
// count; clr holds it at zero so a new frame starts on a full bit period.
module rat_baud_gen #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic CLK,
  input  logic RESET,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    tick  = (cnt_q == LAST) && !clr;
    cnt_d = cnt_q + CW'(1);
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rat_uart_tx_port.sv
// Port-mapped 8N1 UART transmitter for the RAT MCU: one holding register in
// front of the shifter, a status byte for the input mux and a drain interrupt.
module rat_uart_tx_port
  import rat_io_pkg::*;
#(
  parameter int         CLK_FREQ  = 100_000_000,
  parameter int         BAUD      = 115200,
  parameter logic [7:0] DATA_ID   = DATA_PORT_ID,
  parameter logic [7:0] CTRL_ID   = CTRL_PORT_ID,
  parameter logic [7:0] STATUS_ID = STATUS_PORT_ID
) (
  input  logic               CLK,
  input  logic               RESET,
  rat_uart_tx_port_if.slave  bus,
  output logic               TX,
  output logic               INTR
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);

  tx_state_t  state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic       ovf_q, ovf_d;
  logic       pend_q, pend_d;
  logic       intr_en_q, intr_en_d;
  logic       intr_q, intr_d;
  logic       tx_q, tx_d;
  logic       strb_q, strb_d;

  logic       wr_evt;
  logic       data_wr;
  logic       ctrl_wr;
  logic       drain;
  logic       pend_set;
  logic       tick;
  logic       busy;
  logic [7:0] status;

  rat_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .CLK   (CLK),
    .RESET (RESET),
    .clr   (state_q == IDLE),
    .tick  (tick)
  );

  // The MCU holds IO_STRB for two CLKs per write; only its rising edge counts.
  always_comb begin
    strb_d  = bus.IO_STRB;
    wr_evt  = bus.IO_STRB & ~strb_q;
    data_wr = wr_evt && (bus.PORT_ID == DATA_ID);
    ctrl_wr = wr_evt && (bus.PORT_ID == CTRL_ID);
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    drain     = 1'b0;
    pend_set  = 1'b0;

    case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          state_d = START;
          shift_d = hold_q;
          drain   = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (hold_full_q) begin
            state_d = START;
            shift_d = hold_q;
            drain   = 1'b1;
          end else begin
            state_d  = IDLE;
            pend_set = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // A write landing in the same cycle the shifter takes the held byte is
  // accepted, since the holding register is being vacated at that edge.
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    ovf_d       = ovf_q;
    pend_d      = pend_q;
    intr_en_d   = intr_en_q;

    if (drain) begin
      hold_full_d = 1'b0;
    end
    if (data_wr) begin
      if (!hold_full_q || drain) begin
        hold_d      = bus.OUT_PORT;
        hold_full_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
    if (ctrl_wr) begin
      intr_en_d = bus.OUT_PORT[CTRL_INTR_EN];
      if (bus.OUT_PORT[CTRL_CLR_PEND]) begin
        pend_d = 1'b0;
      end
      if (bus.OUT_PORT[CTRL_CLR_OVF]) begin
        ovf_d = 1'b0;
      end
    end
    if (pend_set) begin
      pend_d = 1'b1;
    end

    intr_d = pend_q & intr_en_q;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      ovf_q       <= 1'b0;
      pend_q      <= 1'b0;
      intr_en_q   <= 1'b0;
      intr_q      <= 1'b0;
      tx_q        <= 1'b1;
      strb_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      ovf_q       <= ovf_d;
      pend_q      <= pend_d;
      intr_en_q   <= intr_en_d;
      intr_q      <= intr_d;
      tx_q        <= tx_d;
      strb_q      <= strb_d;
    end
  end

  always_comb begin
    busy   = (state_q != IDLE);
    status = 8'h00;
    status[STAT_BUSY]      = busy;
    status[STAT_HOLD_FULL] = hold_full_q;
    status[STAT_PEND]      = pend_q;
    status[STAT_OVF]       = ovf_q;

    bus.IN_SEL  = (bus.PORT_ID == STATUS_ID);
    bus.IN_DATA = bus.IN_SEL ? status : 8'h00;
  end

  assign TX   = tx_q;
  assign INTR = intr_q;

endmodule

// File: tb/tb_rat_uart_tx_port.sv
// Bench for rat_uart_tx_port at 10 clocks per bit: logs the line, status and
// interrupt every cycle and compares them against an ideal 8N1 timeline.
module tb_rat_uart_tx_port;
  import rat_io_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx;
  logic intr;

  rat_uart_tx_port_if bus ();

  rat_uart_tx_port #(
    .CLK_FREQ (1000),
    .BAUD     (100)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus.slave),
    .TX    (tx),
    .INTR  (intr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Index i holds values present after posedge number i+1.
  logic       tx_hist[$];
  logic [7:0] st_hist[$];
  logic       int_hist[$];
  always @(negedge clk) begin
    tx_hist.push_back(tx);
    st_hist.push_back(bus.IN_DATA);
    int_hist.push_back(intr);
  end

  int checks = 0;
  int errors = 0;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d, want completion", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  // Drives one strobe of len cycles, no earlier than cycle 'at'; ev = drive cycle.
  task automatic write_port(input logic [7:0] id, input logic [7:0] data,
                            input int len, input int at, output int ev);
    do begin @(posedge clk); #1; end while (cyc < at);
    bus.PORT_ID  = id;
    bus.OUT_PORT = data;
    bus.IO_STRB  = 1'b1;
    ev = cyc;
    repeat (len) begin @(posedge clk); #1; end
    bus.IO_STRB = 1'b0;
    bus.PORT_ID = STATUS_PORT_ID;
  endtask

  task automatic wait_hist(input int idx);
    while (tx_hist.size() <= idx) @(negedge clk);
    #1;
  endtask

  // Ideal 8N1 waveform at 10 samples per bit starting at line index s.
  function automatic int wave_errs(input int s, input logic [7:0] d);
    int n = 0;
    logic e;
    for (int t = 0; t < 100; t++) begin
      if (t < 10) e = 1'b0;
      else if (t >= 90) e = 1'b1;
      else e = d[t/10 - 1];
      if (tx_hist[s+t] !== e) n++;
    end
    return n;
  endfunction

  function automatic int count_low(input int a, input int n);
    int c = 0;
    for (int i = a; i < a + n; i++) if (tx_hist[i] !== 1'b1) c++;
    return c;
  endfunction

  function automatic int count_busy(input int a, input int n);
    int c = 0;
    for (int i = a; i < a + n; i++) if (st_hist[i][STAT_BUSY] === 1'b1) c++;
    return c;
  endfunction

  function automatic int count_intr(input int a, input int n);
    int c = 0;
    for (int i = a; i < a + n; i++) if (int_hist[i] !== 1'b0) c++;
    return c;
  endfunction

  task automatic test_reset();
    int ev, k;
    bus.PORT_ID = STATUS_PORT_ID; bus.OUT_PORT = 8'h00; bus.IO_STRB = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", tx); end
    checks++; if (intr !== 1'b0) begin errors++; $display("FAIL reset_intr got %b want 0", intr); end
    checks++; if (bus.IN_DATA !== 8'h00) begin errors++; $display("FAIL reset_status got %h want 00", bus.IN_DATA); end
    rst = 1'b0;
    write_port(DATA_PORT_ID, 8'hA5, 1, 0, ev);
    do begin @(posedge clk); #1; end while (cyc < ev + 37);
    k = cyc;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    wait_hist(k + 100);
    checks++; if (st_hist[k-1][STAT_BUSY] !== 1'b1) begin errors++; $display("FAIL reset_pre_busy got %b want 1", st_hist[k-1][STAT_BUSY]); end
    checks++; if (tx_hist[k] !== 1'b1) begin errors++; $display("FAIL reset_mid_tx got %b want 1", tx_hist[k]); end
    checks++; if (st_hist[k] !== 8'h00) begin errors++; $display("FAIL reset_mid_status got %h want 00", st_hist[k]); end
    checks++; if (int_hist[k] !== 1'b0) begin errors++; $display("FAIL reset_mid_intr got %b want 0", int_hist[k]); end
    checks++; if (count_low(k, 100) != 0) begin errors++; $display("FAIL reset_line_idle got %0d low samples want 0", count_low(k, 100)); end
    $display("reset: mid-frame reset at cycle %0d", k);
  endtask

  task automatic test_single();
    int ev, s, len;
    logic [7:0] d;
    logic [9:0] got;
    for (int it = 0; it < 3; it++) begin
      d   = (it == 0) ? 8'hA5 : 8'($urandom);
      len = (it == 0) ? 2 : $urandom_range(1, 4);
      write_port(DATA_PORT_ID, d, len, 0, ev);
      s = ev + 1;
      wait_hist(s + 110);
      for (int b = 0; b < 10; b++) got[b] = tx_hist[s + 10*b + 5];
      checks++; if (tx_hist[s-1] !== 1'b1 || tx_hist[s] !== 1'b0) begin errors++; $display("FAIL single_fall got %b%b want 10", tx_hist[s-1], tx_hist[s]); end
      checks++; if (got !== {1'b1, d, 1'b0}) begin errors++; $display("FAIL single_bits got %b want %b", got, {1'b1, d, 1'b0}); end
      checks++; if (wave_errs(s, d) != 0) begin errors++; $display("FAIL single_wave got %0d bad samples want 0", wave_errs(s, d)); end
      checks++; if (count_busy(s + 5, 95) != 95) begin errors++; $display("FAIL single_busy got %0d want 95", count_busy(s + 5, 95)); end
      checks++; if (st_hist[s+100][3:0] !== 4'b0100) begin errors++; $display("FAIL single_end_status got %b want 0100", st_hist[s+100][3:0]); end
      checks++; if (count_low(s + 100, 10) != 0) begin errors++; $display("FAIL single_extra_frame got %0d low want 0", count_low(s + 100, 10)); end
      $display("single: byte %h strobe %0d frame at %0d", d, len, s);
    end
  endtask

  task automatic test_back_to_back();
    int ev1, ev2, s1, len;
    logic [7:0] a, b;
    for (int it = 0; it < 2; it++) begin
      a   = (it == 0) ? 8'h55 : 8'($urandom);
      b   = (it == 0) ? 8'h0F : 8'($urandom);
      len = $urandom_range(1, 3);
      write_port(DATA_PORT_ID, a, 1, 0, ev1);
      s1 = ev1 + 1;
      write_port(DATA_PORT_ID, b, len, ev1 + $urandom_range(10, 80), ev2);
      wait_hist(s1 + 215);
      checks++; if (st_hist[ev2-2][1:0] !== 2'b01) begin errors++; $display("FAIL b2b_before got %b want 01", st_hist[ev2-2][1:0]); end
      checks++; if (st_hist[ev2+len][1:0] !== 2'b11) begin errors++; $display("FAIL b2b_held got %b want 11", st_hist[ev2+len][1:0]); end
      checks++; if (wave_errs(s1, a) != 0) begin errors++; $display("FAIL b2b_first got %0d bad samples want 0", wave_errs(s1, a)); end
      checks++; if (wave_errs(s1 + 100, b) != 0) begin errors++; $display("FAIL b2b_second got %0d bad samples want 0", wave_errs(s1 + 100, b)); end
      checks++; if (count_low(s1 + 200, 15) != 0) begin errors++; $display("FAIL b2b_tail got %0d low want 0", count_low(s1 + 200, 15)); end
      checks++; if (st_hist[s1+200][3:0] !== 4'b0100) begin errors++; $display("FAIL b2b_end_status got %b want 0100", st_hist[s1+200][3:0]); end
      $display("back_to_back: %h then %h frames at %0d and %0d", a, b, s1, s1 + 100);
    end
  endtask

  task automatic test_overflow();
    int ev1, ev2, ev3, evc, s1;
    logic [7:0] a, b;
    a = 8'($urandom); b = 8'($urandom);
    write_port(DATA_PORT_ID, a, 1, 0, ev1);
    s1 = ev1 + 1;
    write_port(DATA_PORT_ID, b, 2, ev1 + 20, ev2);
    write_port(DATA_PORT_ID, 8'hFF, 2, ev2 + 10, ev3);
    wait_hist(s1 + 350);
    checks++; if (st_hist[ev3+3][STAT_OVF] !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", st_hist[ev3+3][STAT_OVF]); end
    checks++; if (wave_errs(s1, a) + wave_errs(s1 + 100, b) != 0) begin errors++; $display("FAIL ovf_frames got %0d bad samples want 0", wave_errs(s1, a) + wave_errs(s1 + 100, b)); end
    checks++; if (count_low(s1 + 200, 150) != 0) begin errors++; $display("FAIL ovf_dropped got %0d low want 0", count_low(s1 + 200, 150)); end
    write_port(CTRL_PORT_ID, 8'h04, 2, 0, evc);
    wait_hist(evc + 4);
    checks++; if (st_hist[evc+3][STAT_OVF] !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", st_hist[evc+3][STAT_OVF]); end
    $display("overflow: %h %h kept, FF dropped", a, b);

    // Third write lands exactly on the edge where the held byte is taken.
    a = 8'($urandom); b = 8'($urandom);
    write_port(DATA_PORT_ID, a, 1, 0, ev1);
    s1 = ev1 + 1;
    write_port(DATA_PORT_ID, b, 1, ev1 + 30, ev2);
    write_port(DATA_PORT_ID, 8'h3C, 1, s1 + 100, ev3);
    wait_hist(s1 + 320);
    checks++; if (ev3 != s1 + 100) begin errors++; $display("FAIL drain_align got %0d want %0d", ev3, s1 + 100); end
    checks++; if (st_hist[s1+102][STAT_OVF] !== 1'b0 || st_hist[s1+102][STAT_HOLD_FULL] !== 1'b1) begin errors++; $display("FAIL drain_status got %b want ovf0 hold1", st_hist[s1+102][3:0]); end
    checks++; if (wave_errs(s1 + 200, 8'h3C) != 0) begin errors++; $display("FAIL drain_third got %0d bad samples want 0", wave_errs(s1 + 200, 8'h3C)); end
    checks++; if (wave_errs(s1, a) + wave_errs(s1 + 100, b) != 0) begin errors++; $display("FAIL drain_first got %0d bad samples want 0", wave_errs(s1, a) + wave_errs(s1 + 100, b)); end
    checks++; if (count_low(s1 + 300, 20) != 0) begin errors++; $display("FAIL drain_tail got %0d low want 0", count_low(s1 + 300, 20)); end
    $display("drain_write: %h %h 3C frames at %0d", a, b, s1);
  endtask

  task automatic test_interrupt();
    int ev, evc, s;
    logic [7:0] d;
    write_port(CTRL_PORT_ID, 8'h02, 1, 0, evc);
    write_port(CTRL_PORT_ID, 8'h01, 1, 0, evc);
    write_port(DATA_PORT_ID, 8'h00, 2, 0, ev);
    s = ev + 1;
    wait_hist(s + 110);
    checks++; if (st_hist[s-3][STAT_PEND] !== 1'b0) begin errors++; $display("FAIL intr_pend_clr got %b want 0", st_hist[s-3][STAT_PEND]); end
    checks++; if (count_intr(s, 101) != 0) begin errors++; $display("FAIL intr_early got %0d high want 0", count_intr(s, 101)); end
    checks++; if (int_hist[s+101] !== 1'b1) begin errors++; $display("FAIL intr_rise got %b want 1", int_hist[s+101]); end
    checks++; if (wave_errs(s, 8'h00) != 0) begin errors++; $display("FAIL intr_frame got %0d bad samples want 0", wave_errs(s, 8'h00)); end
    write_port(CTRL_PORT_ID, 8'h03, 1, 0, evc);
    wait_hist(evc + 5);
    checks++; if (int_hist[evc+3] !== 1'b0 || st_hist[evc+3][STAT_PEND] !== 1'b0) begin errors++; $display("FAIL intr_clear got intr %b pend %b want 0 0", int_hist[evc+3], st_hist[evc+3][STAT_PEND]); end
    $display("interrupt: rise at %0d cleared at %0d", s + 101, evc);

    // Interrupts masked; a clear-pend write on the frame-end edge loses to the set.
    write_port(CTRL_PORT_ID, 8'h00, 1, 0, evc);
    d = 8'($urandom);
    write_port(DATA_PORT_ID, d, 1, 0, ev);
    s = ev + 1;
    write_port(CTRL_PORT_ID, 8'h02, 1, s + 100, evc);
    wait_hist(s + 135);
    checks++; if (evc != s + 100) begin errors++; $display("FAIL setwins_align got %0d want %0d", evc, s + 100); end
    checks++; if (st_hist[s+105][STAT_PEND] !== 1'b1) begin errors++; $display("FAIL setwins_pend got %b want 1", st_hist[s+105][STAT_PEND]); end
    checks++; if (count_intr(s, 135) != 0) begin errors++; $display("FAIL masked_intr got %0d high want 0", count_intr(s, 135)); end
    $display("interrupt_masked: byte %h pend kept", d);
  endtask

  task automatic test_read_mux();
    logic [7:0] id;
    @(posedge clk); #1;
    bus.PORT_ID = STATUS_PORT_ID;
    #1;
    checks++; if (bus.IN_SEL !== 1'b1 || bus.IN_DATA !== 8'h04) begin errors++; $display("FAIL mux_status got sel %b data %h want 1 04", bus.IN_SEL, bus.IN_DATA); end
    for (int i = 0; i < 4; i++) begin
      id = (i == 0) ? SWITCHES_PORT_ID : 8'($urandom);
      if (id == STATUS_PORT_ID) id = 8'h26;
      bus.PORT_ID = id;
      #1;
      checks++; if (bus.IN_SEL !== 1'b0 || bus.IN_DATA !== 8'h00) begin errors++; $display("FAIL mux_other id %h got sel %b data %h want 0 00", id, bus.IN_SEL, bus.IN_DATA); end
    end
    bus.PORT_ID = STATUS_PORT_ID;
    $display("read_mux: status and %0d foreign IDs", 4);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_interrupt();
    test_read_mux();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
